// File: rtl/div8x4_seq_if.sv
// Request/result bundle for the sequential divider.
// The master drives the operands and start; the slave returns status and results.
interface div8x4_seq_if #(
  parameter int DW = 8,
  parameter int VW = 4
) ();
  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          busy;
  logic          done;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div8x4_seq.sv
// Sequential restoring divider, one quotient bit per clock.
// Unsigned DW-bit dividend by VW-bit divisor; divide by zero flagged without iterating.
//
// state  | meaning
// IDLE   | waiting for start; results from the last operation held
// RUN    | one restoring iteration per clock, DW iterations in total
// DONE   | results valid, done pulse for one cycle
module div8x4_seq #(
  parameter int DW = 8,
  parameter int VW = 4
) (
  input  logic         clk,
  input  logic         rst,
  div8x4_seq_if.slave  bus
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] d_q, d_d;
  logic [VW-1:0] v_q, v_d;
  // After a restore step P < V, so the top bit of P is always 0 and is not stored.
  logic [VW-1:0] p_q, p_d;
  logic [DW-1:0] quo_q, quo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dbz_q, dbz_d;

  logic [VW:0]   p_shift;
  logic          accept;

  assign accept  = (state_q == S_IDLE) && bus.start;
  assign p_shift = {p_q, d_q[DW-1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      d_q     <= '0;
      v_q     <= '0;
      p_q     <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      v_q     <= v_d;
      p_q     <= p_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = (bus.divisor == '0) ? S_DONE : S_RUN;
      S_RUN:   if (cnt_q == '0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    d_d   = d_q;
    v_d   = v_q;
    p_d   = p_q;
    quo_d = quo_q;
    cnt_d = cnt_q;
    dbz_d = dbz_q;
    if (accept) begin
      d_d   = bus.dividend;
      v_d   = bus.divisor;
      cnt_d = CW'(DW - 1);
      if (bus.divisor == '0) begin
        quo_d = '1;
        p_d   = bus.dividend[VW-1:0];
        dbz_d = 1'b1;
      end else begin
        quo_d = '0;
        p_d   = '0;
        dbz_d = 1'b0;
      end
    end else if (state_q == S_RUN) begin
      d_d   = {d_q[DW-2:0], 1'b0};
      cnt_d = cnt_q - CW'(1);
      if (p_shift >= {1'b0, v_q}) begin
        p_d   = VW'(p_shift - {1'b0, v_q});
        quo_d = {quo_q[DW-2:0], 1'b1};
      end else begin
        p_d   = p_shift[VW-1:0];
        quo_d = {quo_q[DW-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    bus.busy        = (state_q != S_IDLE);
    bus.done        = (state_q == S_DONE);
    bus.quotient    = quo_q;
    bus.remainder   = p_q;
    bus.div_by_zero = dbz_q;
  end

endmodule
